riscvboy_unified_mem: RTL

Parametrised single-port unified memory subsystem for the riscvboy SoC. It replaces the separate fixed-size instruction and data memories with one synchronous word array. The core's instruction-fetch port and data port share that array through an arbiter with valid/ready handshakes, byte-lane write strobes, a configurable base address and out-of-range/misalignment error responses. It sits between `riscvboy_core_top` and the memory map.

---
 rtl/riscvboy_unified_mem.sv | 121 ++++++++++++
 1 files changed

// File: rtl/riscvboy_unified_mem.sv
// riscvboy_unified_mem: one synchronous word array shared by the instruction-fetch
// and data ports. A combinational arbiter grants one access per cycle. Every
// accepted request answers with a one-cycle response pulse on the next cycle.
module riscvboy_unified_mem #(
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         DEPTH     = 4096,
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter int unsigned         ARB_MODE  = 0
) (
    input  logic                  clk_sys,
    input  logic                  rst,

    input  logic                  i_ireq_valid,
    output logic                  o_ireq_ready,
    input  logic [ADDR_W-1:0]     i_ireq_addr,
    output logic                  o_irsp_valid,
    output logic [DATA_W-1:0]     o_irsp_data,
    output logic                  o_irsp_err,

    input  logic                  i_dreq_valid,
    output logic                  o_dreq_ready,
    input  logic                  i_dreq_we,
    input  logic [ADDR_W-1:0]     i_dreq_addr,
    input  logic [DATA_W-1:0]     i_dreq_wdata,
    input  logic [DATA_W/8-1:0]   i_dreq_wstrb,
    output logic                  o_drsp_valid,
    output logic [DATA_W-1:0]     o_drsp_rdata,
    output logic                  o_drsp_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          ROUND_ROBIN = (ARB_MODE != 0);
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(STRB_W - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    grant_t              last_grant;
    logic                grant_d;
    logic                grant_i;
    logic [ADDR_W-1:0]   acc_addr;
    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   word_full;
    logic [IDX_W-1:0]    acc_idx;
    logic                addr_err;
    logic                mem_wr;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Arbitration: data port wins unless round-robin says the fetch port is due
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (!rst) begin
            grant_d = i_dreq_valid &&
                      (!ROUND_ROBIN || !i_ireq_valid || (last_grant == GRANT_I));
            grant_i = i_ireq_valid && !grant_d;
        end
    end

    assign o_dreq_ready = grant_d;
    assign o_ireq_ready = grant_i;

    // Decode the granted address into a word index and an error flag
    always_comb begin
        acc_addr  = grant_d ? i_dreq_addr : i_ireq_addr;
        offset    = acc_addr - BASE_ADDR;
        word_full = offset >> LSB_W;
        acc_idx   = IDX_W'(word_full);
        addr_err  = (acc_addr < BASE_ADDR) ||
                    ((offset & LOW_MASK) != '0) ||
                    (word_full >= DEPTH_A);
    end

    assign mem_wr  = grant_d && i_dreq_we && !addr_err;
    assign rd_word = mem[acc_idx];

    // Byte-lane write into the array; contents are deliberately not reset
    always_ff @(posedge clk_sys) begin
        if (mem_wr) begin
            for (int k = 0; k < int'(STRB_W); k++) begin
                if (i_dreq_wstrb[k]) begin
                    mem[acc_idx][k*8 +: 8] <= i_dreq_wdata[k*8 +: 8];
                end
            end
        end
    end

    // Registered response pulses and grant history
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            o_irsp_valid <= 1'b0;
            o_irsp_err   <= 1'b0;
            o_irsp_data  <= '0;
            o_drsp_valid <= 1'b0;
            o_drsp_err   <= 1'b0;
            o_drsp_rdata <= '0;
            last_grant   <= GRANT_I;
        end else begin
            o_irsp_valid <= grant_i;
            o_irsp_err   <= grant_i && addr_err;
            o_irsp_data  <= (grant_i && !addr_err) ? rd_word : '0;
            o_drsp_valid <= grant_d;
            o_drsp_err   <= grant_d && addr_err;
            o_drsp_rdata <= (grant_d && !i_dreq_we && !addr_err) ? rd_word : '0;
            if (grant_d) begin
                last_grant <= GRANT_D;
            end else if (grant_i) begin
                last_grant <= GRANT_I;
            end
        end
    end

endmodule
